// File: rtl/ps2_zx_pkg.sv
// Shared definitions for the PS/2 to ZX Spectrum keyboard bridge.
// Contents: set-2 prefix scancodes, the host-key enum that indexes the
// held-key flag vector, the host-key to ZX matrix map, and the Fn code table.
package ps2_zx_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_REL   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // One entry per physical host key; grouped roughly by ZX matrix row.
  typedef enum logic [5:0] {
    K_LSHIFT, K_RSHIFT, K_Z, K_X, K_C, K_V,
    K_A, K_S, K_D, K_F, K_G,
    K_Q, K_W, K_E, K_R, K_T,
    K_1, K_2, K_3, K_4, K_5,
    K_0, K_9, K_8, K_7, K_6,
    K_P, K_O, K_I, K_U, K_Y,
    K_ENTER, K_L, K_K, K_J, K_H,
    K_SPACE, K_LCTRL, K_RCTRL, K_M, K_N, K_B,
    K_BKSP, K_ESC, K_LEFT, K_RIGHT, K_UP, K_DOWN,
    K_LALT, K_RALT,
    K_F1, K_F2, K_F3, K_F4, K_F5, K_F6, K_F7, K_F8, K_F9, K_F10, K_F11,
    K_COUNT
  } hkey_t;

  localparam int unsigned NUM_KEYS = int'(K_COUNT);

  typedef enum logic [1:0] {ST_IDLE, ST_PREFIX, ST_SKIP} dec_state_t;

  typedef struct packed {
    logic       hit;   // key drives a matrix bit
    logic       cs;    // key additionally asserts Caps Shift
    logic [2:0] row;
    logic [2:0] col;
  } kmap_t;

  typedef struct packed {
    logic  valid;
    hkey_t key;
  } lookup_t;

  // F1..F11 in order
  localparam logic [7:0] FN_CODES [11] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03,
                                           8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78};

  function automatic kmap_t km(input int unsigned r, input int unsigned c, input logic cs);
    kmap_t m;
    m.hit = 1'b1;
    m.cs  = cs;
    m.row = 3'(r);
    m.col = 3'(c);
    return m;
  endfunction

  function automatic kmap_t key_map(input hkey_t k);
    kmap_t m;
    m = '0;
    case (k)
      K_LSHIFT, K_RSHIFT: m = km(0, 0, 1'b0);
      K_Z: m = km(0, 1, 1'b0);  K_X: m = km(0, 2, 1'b0);
      K_C: m = km(0, 3, 1'b0);  K_V: m = km(0, 4, 1'b0);
      K_A: m = km(1, 0, 1'b0);  K_S: m = km(1, 1, 1'b0);  K_D: m = km(1, 2, 1'b0);
      K_F: m = km(1, 3, 1'b0);  K_G: m = km(1, 4, 1'b0);
      K_Q: m = km(2, 0, 1'b0);  K_W: m = km(2, 1, 1'b0);  K_E: m = km(2, 2, 1'b0);
      K_R: m = km(2, 3, 1'b0);  K_T: m = km(2, 4, 1'b0);
      K_1: m = km(3, 0, 1'b0);  K_2: m = km(3, 1, 1'b0);  K_3: m = km(3, 2, 1'b0);
      K_4: m = km(3, 3, 1'b0);  K_5: m = km(3, 4, 1'b0);
      K_0: m = km(4, 0, 1'b0);  K_9: m = km(4, 1, 1'b0);  K_8: m = km(4, 2, 1'b0);
      K_7: m = km(4, 3, 1'b0);  K_6: m = km(4, 4, 1'b0);
      K_P: m = km(5, 0, 1'b0);  K_O: m = km(5, 1, 1'b0);  K_I: m = km(5, 2, 1'b0);
      K_U: m = km(5, 3, 1'b0);  K_Y: m = km(5, 4, 1'b0);
      K_ENTER: m = km(6, 0, 1'b0); K_L: m = km(6, 1, 1'b0); K_K: m = km(6, 2, 1'b0);
      K_J: m = km(6, 3, 1'b0);  K_H: m = km(6, 4, 1'b0);
      K_SPACE: m = km(7, 0, 1'b0);
      K_LCTRL, K_RCTRL: m = km(7, 1, 1'b0);
      K_M: m = km(7, 2, 1'b0);  K_N: m = km(7, 3, 1'b0);  K_B: m = km(7, 4, 1'b0);
      K_BKSP:  m = km(4, 0, 1'b1);
      K_ESC:   m = km(7, 0, 1'b1);
      K_LEFT:  m = km(3, 4, 1'b1);
      K_RIGHT: m = km(4, 2, 1'b1);
      K_UP:    m = km(4, 3, 1'b1);
      K_DOWN:  m = km(4, 4, 1'b1);
      default: m = '0;  // Alt and Fn keys have no matrix position
    endcase
    return m;
  endfunction

  function automatic lookup_t sc_lookup(input logic ext, input logic [7:0] code);
    lookup_t r;
    r.valid = 1'b1;
    r.key   = K_A;
    if (ext) begin
      case (code)
        8'h14: r.key = K_RCTRL;  8'h11: r.key = K_RALT;
        8'h6B: r.key = K_LEFT;   8'h74: r.key = K_RIGHT;
        8'h75: r.key = K_UP;     8'h72: r.key = K_DOWN;
        default: r.valid = 1'b0;
      endcase
    end else begin
      case (code)
        8'h1C: r.key = K_A; 8'h32: r.key = K_B; 8'h21: r.key = K_C; 8'h23: r.key = K_D;
        8'h24: r.key = K_E; 8'h2B: r.key = K_F; 8'h34: r.key = K_G; 8'h33: r.key = K_H;
        8'h43: r.key = K_I; 8'h3B: r.key = K_J; 8'h42: r.key = K_K; 8'h4B: r.key = K_L;
        8'h3A: r.key = K_M; 8'h31: r.key = K_N; 8'h44: r.key = K_O; 8'h4D: r.key = K_P;
        8'h15: r.key = K_Q; 8'h2D: r.key = K_R; 8'h1B: r.key = K_S; 8'h2C: r.key = K_T;
        8'h3C: r.key = K_U; 8'h2A: r.key = K_V; 8'h1D: r.key = K_W; 8'h22: r.key = K_X;
        8'h35: r.key = K_Y; 8'h1A: r.key = K_Z;
        8'h45: r.key = K_0; 8'h16: r.key = K_1; 8'h1E: r.key = K_2; 8'h26: r.key = K_3;
        8'h25: r.key = K_4; 8'h2E: r.key = K_5; 8'h36: r.key = K_6; 8'h3D: r.key = K_7;
        8'h3E: r.key = K_8; 8'h46: r.key = K_9;
        8'h5A: r.key = K_ENTER;  8'h29: r.key = K_SPACE;
        8'h12: r.key = K_LSHIFT; 8'h59: r.key = K_RSHIFT;
        8'h14: r.key = K_LCTRL;  8'h11: r.key = K_LALT;
        8'h66: r.key = K_BKSP;   8'h76: r.key = K_ESC;
        default: r.valid = 1'b0;
      endcase
      for (int unsigned i = 0; i < 11; i++) begin
        if (code == FN_CODES[i]) begin
          r.valid = 1'b1;
          r.key   = hkey_t'(int'(K_F1) + i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_zx_keyboard_rx.sv
// PS/2 frame receiver: 2-flop synchronisers, FILTER-sample debounce on clock
// and data, falling-edge bit strobe, 11-bit frame check and inter-edge watchdog.
// Ports: clk_sys/reset (sync, active-high), i_ps2_clk/i_ps2_data (async lines),
//        o_byte_valid (1-cycle pulse), o_byte (received data byte).
module ps2_rx #(
  parameter int unsigned FILTER    = 8,
  parameter int unsigned TIMEOUT_W = 15
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte
);
  localparam int unsigned CW = $clog2(FILTER + 1);

  // index 0 = clock line, 1 = data line
  logic [1:0]           r_s1, r_s2, r_filt;
  logic [CW-1:0]        r_cnt [2];
  logic                 r_strobe;
  logic [3:0]           r_bitcnt;
  logic [8:0]           r_shift;
  logic [TIMEOUT_W-1:0] r_wd;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_s1         <= '1;
      r_s2         <= '1;
      r_filt       <= '1;
      r_cnt[0]     <= '0;
      r_cnt[1]     <= '0;
      r_strobe     <= 1'b0;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_wd         <= '0;
      o_byte_valid <= 1'b0;
      o_byte       <= '0;
    end else begin
      r_s1         <= {i_ps2_data, i_ps2_clk};
      r_s2         <= r_s1;
      r_strobe     <= 1'b0;
      o_byte_valid <= 1'b0;

      // Accept a new level only after FILTER consecutive differing samples.
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_s2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(FILTER - 1)) begin
          r_filt[i] <= r_s2[i];
          r_cnt[i]  <= '0;
          if (i == 0 && !r_s2[i]) r_strobe <= 1'b1;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end

      if (r_strobe) begin
        r_wd <= '0;
        if (r_bitcnt == 4'd0) begin
          if (!r_filt[1]) r_bitcnt <= 4'd1;       // start bit
        end else if (r_bitcnt < 4'd10) begin
          r_shift  <= {r_filt[1], r_shift[8:1]};  // 8 data LSB first, then parity
          r_bitcnt <= r_bitcnt + 4'd1;
        end else begin
          if (r_filt[1] && ^r_shift) begin
            o_byte_valid <= 1'b1;
            o_byte       <= r_shift[7:0];
          end
          r_bitcnt <= '0;
        end
      end else if (r_bitcnt != 4'd0) begin
        if (&r_wd) begin
          r_bitcnt <= '0;
          r_wd     <= '0;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 keyboard to ZX Spectrum 8x5 matrix bridge.
// Ports: clk_sys/reset (sync, active-high), ps2_kbd_clk/ps2_kbd_data (async),
//        addr (addr[15:8] active-low row select), key_data (active-low ULA bits),
//        Fn[11:1] (held host F-keys), mod (held Alt/Ctrl/Shift).
module ps2_zx_keyboard
  import ps2_zx_pkg::*;
#(
  parameter int unsigned FILTER    = 8,
  parameter int unsigned TIMEOUT_W = 15
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  input  logic [15:0] addr,
  output logic [4:0]  key_data,
  output logic [11:1] Fn,
  output logic [2:0]  mod
);
  logic                w_valid;
  logic [7:0]          w_byte;
  lookup_t             w_lk;
  kmap_t               w_km;
  logic [7:0][4:0]     w_mat;
  logic [4:0]          w_sel;
  logic                w_unused_addr;

  dec_state_t          r_state;
  logic                r_ext, r_rel;
  logic [2:0]          r_skip;
  logic [NUM_KEYS-1:0] r_held;

  ps2_rx #(.FILTER(FILTER), .TIMEOUT_W(TIMEOUT_W)) u_rx (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .i_ps2_clk    (ps2_kbd_clk),
    .i_ps2_data   (ps2_kbd_data),
    .o_byte_valid (w_valid),
    .o_byte       (w_byte)
  );

  assign w_lk          = sc_lookup(r_ext, w_byte);
  assign w_unused_addr = ^addr[7:0];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ext   <= 1'b0;
      r_rel   <= 1'b0;
      r_skip  <= '0;
      r_held  <= '0;
    end else if (w_valid) begin
      case (r_state)
        ST_SKIP: begin
          r_skip <= r_skip - 3'd1;
          if (r_skip == 3'd1) r_state <= ST_IDLE;
        end
        default: begin
          if (w_byte == SC_EXT) begin
            r_ext   <= 1'b1;
            r_state <= ST_PREFIX;
          end else if (w_byte == SC_REL) begin
            r_rel   <= 1'b1;
            r_state <= ST_PREFIX;
          end else begin
            // Every non-prefix byte (including AA/FA and unmapped codes) ends the sequence.
            r_ext   <= 1'b0;
            r_rel   <= 1'b0;
            r_state <= ST_IDLE;
            if (w_byte == SC_PAUSE) begin
              r_skip  <= 3'd7;
              r_state <= ST_SKIP;
            end else if (w_lk.valid) begin
              r_held[w_lk.key] <= ~r_rel;
            end
          end
        end
      endcase
    end
  end

  // Matrix bits are rebuilt from per-host-key flags so overlapping sources
  // (e.g. LShift and Backspace both driving CS) release independently.
  always_comb begin
    w_mat = '0;
    w_km  = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      w_km = key_map(hkey_t'(k));
      if (r_held[k] && w_km.hit) begin
        w_mat[w_km.row][w_km.col] = 1'b1;
        if (w_km.cs) w_mat[0][0] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int unsigned r = 0; r < 8; r++) begin
      if (!addr[8 + r]) w_sel = w_sel | w_mat[r];
    end
    key_data = ~w_sel;
  end

  assign Fn  = r_held[int'(K_F11):int'(K_F1)];
  assign mod = {r_held[K_LSHIFT] | r_held[K_RSHIFT],
                r_held[K_LCTRL]  | r_held[K_RCTRL],
                r_held[K_LALT]   | r_held[K_RALT]};
endmodule
